img_frame_writer: RTL and testbench
===================================

// Module: img_frame_writer
// PURPOSE
//  Sink end of the 8-bit raster pixel stream produced by img_rom and the SIFT pipeline stages.
//  Captures one WIDTH x HEIGHT frame in raster order into on-chip block RAM.
//  Provides a 1-cycle-latency random-access read port, so downstream stages and the bench
//  can inspect the stored frame.
//  Sits at the tail of a stream, such as a filtered or DoG output, before result readout.
// PARAMETERS
//  WIDTH   128  pixels per line
//  HEIGHT  128  lines per frame
//  ADDR_W  $clog2(WIDTH*HEIGHT)  frame address width; derived, do not override
// PORTS
//  clk        in   1         system clock; all logic on rising edge
//  rst        in   1         synchronous reset, ACTIVE-LOW (0 = reset)
//  start      in   1         arm capture of one frame (single-cycle pulse)
//  in_valid   in   1         in_pixel is valid this cycle
//  in_pixel   in   8         stream pixel, raster order
//  busy       out  1         1 while in CAPTURE
//  frame_done out  1         1-cycle pulse when the frame is complete
//  overflow   out  1         sticky: a valid pixel arrived while not capturing
//  pix_count  out  ADDR_W+1  pixels accepted in the current/last frame
//  rd_addr    in   ADDR_W    readback address, y*WIDTH+x
//  rd_data    out  8         mem[rd_addr], registered, 1-cycle latency
//  checksum   out  16        running pixel sum (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//   - State goes to IDLE.
//   - busy, frame_done, overflow, pix_count, checksum and rd_data all go to 0.
//   - RAM contents are not cleared.
//  FSM IDLE -> CAPTURE on start:
//   - Write address, x/y counters, pix_count and checksum clear to 0.
//   - overflow also clears.
//  CAPTURE, on each in_valid=1:
//   - mem[addr] <= in_pixel; addr, pix_count and x increment.
//   - x wraps WIDTH-1 -> 0 with y+1.
//  CAPTURE, in_valid=0: no change; gaps of any length are legal.
//  CAPTURE -> DONE on the accepted pixel with addr == WIDTH*HEIGHT-1.
//   - frame_done=1 in the following cycle only.
//   - busy=0 from that same cycle.
//  DONE: holds pix_count = WIDTH*HEIGHT; start -> CAPTURE, same clears as from IDLE.
//  in_valid=1 in IDLE or DONE: pixel dropped, no RAM write, overflow <= 1.
//  start during CAPTURE: ignored; the frame continues.
//  start and in_valid in the same IDLE/DONE cycle: that pixel is dropped and sets overflow.
//   - Capture starts with the next valid pixel; overflow is then cleared by the start.
//   - Net effect: overflow=0 at the end of that cycle. start clear has priority.
//  Reset mid-CAPTURE: state is abandoned, the partially written RAM is kept.
//   - The next start rewrites from address 0.
//  Read port:
//   - Always active, in every state.
//   - Read-first: a same-cycle read and write of the same address returns the old data.
//  Arithmetic: pix_count saturates by construction at WIDTH*HEIGHT.
// CONFIGURATION
//  FRAME_WRITER_CHECKSUM_EN defined:
//   - checksum = 16-bit modulo sum of every accepted pixel of the current frame.
//   - Cleared on start; updates in the cycle after each write.
//  Not defined: checksum tied to 16'h0000 and no adder is inferred.
//  The port list is identical either way.
// STRUCTURE
//  Package sift_img_pkg holds:
//   - IMG_WIDTH/IMG_HEIGHT defaults (128), PIX_W=8.
//   - fw_state_t enum {FW_IDLE, FW_CAPTURE, FW_DONE}.
//  Sub-module frame_ram:
//   - Simple dual-port RAM: 1 write port, 1 registered read port, read-first.
//   - Depth WIDTH*HEIGHT, infers BRAM.
//  The top level holds the FSM, the counters and the optional checksum.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles -> busy=0, frame_done=0, overflow=0, pix_count=0, checksum=0.
//  2 128x128, start, then 16384 consecutive valids, in_pixel=addr[7:0]:
//     -> frame_done high exactly 1 cycle after the last pixel.
//     -> rd_addr=0x1234 gives rd_data=0x34 one cycle later.
//  3 WIDTH=HEIGHT=4, valid toggling 1,0,1,0... -> pix_count=16, a single frame_done, mem[k]=k.
//  4 After DONE, 3 extra valid pixels -> overflow=1, mem[0] unchanged.
//     A new start clears overflow to 0 and pix_count to 0.
//  5 rst=0 at pix_count=100, then start and 4x4 stream of 0xAA:
//     -> addresses 0..15 hold 0xAA, frame_done pulses once.
//  6 4x4 frame with pixels 0..15:
//     -> checksum=16'h0078 with FRAME_WRITER_CHECKSUM_EN defined.
//     -> checksum=16'h0000 without it.

Source files
------------

// File: rtl/sift_img_pkg.sv
// rtl/sift_img_pkg.sv - shared image geometry, pixel width and frame writer state type
package sift_img_pkg;

  localparam int IMG_WIDTH  = 128;
  localparam int IMG_HEIGHT = 128;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    FW_IDLE    = 2'd0,
    FW_CAPTURE = 2'd1,
    FW_DONE    = 2'd2
  } fw_state_t;

endpackage

// File: rtl/img_frame_writer_if.sv
// rtl/img_frame_writer_if.sv - stream, status and readback bundle of the frame writer
//  start/in_valid/in_pixel : capture control and raster pixel stream
//  busy/frame_done/overflow/pix_count/checksum : capture status
//  rd_addr/rd_data : random-access readback, 1-cycle latency
//  master: stream source and reader side; slave: img_frame_writer side
interface img_frame_writer_if
  import sift_img_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic              busy;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W:0]   pix_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [15:0]       checksum;

  modport master (
    output start, in_valid, in_pixel, rd_addr,
    input  busy, frame_done, overflow, pix_count, rd_data, checksum
  );

  modport slave (
    input  start, in_valid, in_pixel, rd_addr,
    output busy, frame_done, overflow, pix_count, rd_data, checksum
  );
endinterface

// File: rtl/img_frame_writer_ram.sv
// rtl/img_frame_writer_ram.sv - simple dual-port frame RAM, registered read-first read port
//  clk, rst (sync active-low, clears rd_data only), we/waddr/wdata write port,
//  raddr -> rdata one cycle later; contents are never cleared
module frame_ram #(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of mem returns the pre-write value on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end
endmodule

// File: rtl/img_frame_writer.sv
// rtl/img_frame_writer.sv - captures one WIDTH x HEIGHT raster frame into block RAM
//  clk, rst (sync active-low), bus (img_frame_writer_if.slave): start, in_valid, in_pixel,
//  busy, frame_done, overflow, pix_count, rd_addr, rd_data, checksum
//  FRAME_WRITER_CHECKSUM_EN: enables the 16-bit running pixel sum, else checksum is 0
module img_frame_writer
  import sift_img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  img_frame_writer_if.slave  bus
);
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  fw_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W:0]   pix_count;
  logic              frame_done;
  logic              overflow;
  logic              we;
  logic              last_pix;
  logic              arm;

  assign we       = (state == FW_CAPTURE) && bus.in_valid;
  assign last_pix = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
  assign arm      = (state != FW_CAPTURE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FW_IDLE;
      addr       <= '0;
      x          <= '0;
      y          <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (arm) begin
        // start wins over a pixel dropped in the same cycle, so overflow ends up 0.
        state     <= FW_CAPTURE;
        addr      <= '0;
        x         <= '0;
        y         <= '0;
        pix_count <= '0;
        overflow  <= 1'b0;
      end else if (state != FW_CAPTURE) begin
        if (bus.in_valid) overflow <= 1'b1;
      end else if (bus.in_valid) begin
        addr      <= addr + 1'b1;
        pix_count <= pix_count + 1'b1;
        if (x == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
        if (last_pix) begin
          state      <= FW_DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy       = (state == FW_CAPTURE);
  assign bus.frame_done = frame_done;
  assign bus.overflow   = overflow;
  assign bus.pix_count  = pix_count;

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] checksum;

  always_ff @(posedge clk) begin
    if (!rst)     checksum <= '0;
    else if (arm) checksum <= '0;
    else if (we)  checksum <= checksum + 16'(bus.in_pixel);
  end

  assign bus.checksum = checksum;
`else
  assign bus.checksum = 16'h0000;
`endif

  frame_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr),
    .wdata (bus.in_pixel),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );
endmodule

// File: tb/tb_img_frame_writer.sv
// tb/tb_img_frame_writer.sv - directed self-checking bench for img_frame_writer (128x128 and 4x4)
module tb_img_frame_writer;

`ifdef FRAME_WRITER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   pulses_b = 0;
  int   pulses_s = 0;

  always #5 clk = ~clk;

  img_frame_writer_if #(.ADDR_W(14)) bb ();
  img_frame_writer_if #(.ADDR_W(4))  sb ();

  img_frame_writer #(.WIDTH(128), .HEIGHT(128)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  img_frame_writer #(.WIDTH(4), .HEIGHT(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  always @(negedge clk) begin
    if (rst && bb.frame_done) pulses_b++;
    if (rst && sb.frame_done) pulses_s++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bb.start = 0; bb.in_valid = 0; bb.in_pixel = 0; bb.rd_addr = 0;
    sb.start = 0; sb.in_valid = 0; sb.in_pixel = 0; sb.rd_addr = 0;

    // 1: reset state
    rst = 0;
    repeat (2) step();
    check("rst_busy_b",  32'(bb.busy), 0);
    check("rst_done_b",  32'(bb.frame_done), 0);
    check("rst_ovf_b",   32'(bb.overflow), 0);
    check("rst_cnt_b",   32'(bb.pix_count), 0);
    check("rst_ck_b",    32'(bb.checksum), 0);
    check("rst_busy_s",  32'(sb.busy), 0);
    check("rst_cnt_s",   32'(sb.pix_count), 0);
    check("rst_rd_s",    32'(sb.rd_data), 0);
    rst = 1;
    step();

    // 2: full 128x128 frame, pixel = addr[7:0]
    pulses_b = 0;
    bb.start = 1; step(); bb.start = 0;
    check("t2_busy", 32'(bb.busy), 1);
    for (int i = 0; i < 16384; i++) begin
      bb.in_valid = 1;
      bb.in_pixel = i[7:0];
      step();
      if (i == 16382) check("t2_done_early", 32'(bb.frame_done), 0);
      if (i == 16383) begin
        check("t2_done_next", 32'(bb.frame_done), 1);
        check("t2_busy_end",  32'(bb.busy), 0);
        check("t2_cnt",       32'(bb.pix_count), 16384);
      end
    end
    bb.in_valid = 0;
    step();
    check("t2_done_low", 32'(bb.frame_done), 0);
    check("t2_pulses",   32'(pulses_b), 1);
    check("t2_ck",       32'(bb.checksum), CK_EN ? 32'h0000_E000 : 32'h0);
    bb.rd_addr = 14'h1234;
    step();
    check("t2_rd1234", 32'(bb.rd_data), 32'h34);

    // 3 and 6: 4x4 with valid toggling, start mid-frame ignored, pixels 0..15
    pulses_s = 0;
    sb.start = 1; step(); sb.start = 0;
    for (int i = 0; i < 32; i++) begin
      sb.in_valid = (i % 2 == 0);
      sb.in_pixel = 8'(i / 2);
      sb.start    = (i == 5);
      step();
    end
    sb.in_valid = 0; sb.start = 0;
    repeat (2) step();
    check("t3_cnt",    32'(sb.pix_count), 16);
    check("t3_pulses", 32'(pulses_s), 1);
    check("t3_busy",   32'(sb.busy), 0);
    check("t6_ck",     32'(sb.checksum), CK_EN ? 32'h78 : 32'h0);
    for (int k = 0; k < 16; k++) begin
      sb.rd_addr = 4'(k);
      step();
      check($sformatf("t3_mem%0d", k), 32'(sb.rd_data), 32'(k));
    end

    // 4: valids after DONE, then start with a simultaneous valid
    sb.in_valid = 1; sb.in_pixel = 8'hFF;
    repeat (3) step();
    sb.in_valid = 0;
    check("t4_ovf",     32'(sb.overflow), 1);
    check("t4_cnt_hold", 32'(sb.pix_count), 16);
    sb.rd_addr = 0;
    step();
    check("t4_mem0", 32'(sb.rd_data), 0);
    sb.start = 1; sb.in_valid = 1; sb.in_pixel = 8'h55;
    step();
    sb.start = 0; sb.in_valid = 0;
    check("t4_ovf_clr", 32'(sb.overflow), 0);
    check("t4_cnt_clr", 32'(sb.pix_count), 0);
    check("t4_busy",    32'(sb.busy), 1);
    check("t4_ck_clr",  32'(sb.checksum), 0);
    step();
    check("t4_mem0_kept", 32'(sb.rd_data), 0);

    // 5: reset mid-capture, then a fresh 4x4 frame of 0xAA
    bb.start = 1; step(); bb.start = 0;
    for (int i = 0; i < 100; i++) begin
      bb.in_valid = 1; bb.in_pixel = 8'hEE;
      sb.in_valid = (i < 3); sb.in_pixel = 8'h11;
      step();
    end
    bb.in_valid = 0; sb.in_valid = 0;
    check("t5_cnt100", 32'(bb.pix_count), 100);
    rst = 0;
    step();
    check("t5_rst_cnt_b",  32'(bb.pix_count), 0);
    check("t5_rst_busy_b", 32'(bb.busy), 0);
    check("t5_rst_busy_s", 32'(sb.busy), 0);
    check("t5_rst_rd_s",   32'(sb.rd_data), 0);
    rst = 1;
    step();
    pulses_s = 0;
    sb.start = 1; step(); sb.start = 0;
    for (int i = 0; i < 16; i++) begin
      sb.in_valid = 1; sb.in_pixel = 8'hAA;
      step();
    end
    sb.in_valid = 0;
    repeat (2) step();
    check("t5_pulses", 32'(pulses_s), 1);
    check("t5_ck",     32'(sb.checksum), CK_EN ? 32'h0AA0 : 32'h0);
    for (int k = 0; k < 16; k++) begin
      sb.rd_addr = 4'(k);
      step();
      check($sformatf("t5_mem%0d", k), 32'(sb.rd_data), 32'hAA);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
